// File: rtl/regfile_ctrl.sv
// regfile_ctrl: two-requester round-robin controller for a shared register file.
// Each requester issues single read/write transactions through a req/ack handshake.
// A clear request takes priority over pending requests and pulses the regfile clear for one cycle.
// Every output is registered.
module regfile_ctrl #(
    parameter int AW = 3,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    input  logic          clr_req,
    output logic          clr_done,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic          rf_load,
    output logic          rf_clr,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_din,
    input  logic [DW-1:0] rf_q
);

    typedef enum logic [1:0] {IDLE, XFER, CLR, DONE} state_t;

    state_t state;
    logic   rr;       // last tie winner: 0 = A, 1 = B; the other side wins the next tie
    logic   lat_we;   // write flag of the granted command

    logic          any_req;
    logic          tie;
    logic          win_b;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Pick the winner among pending requesters and mux its command fields.
    always_comb begin
        any_req   = req_a | req_b;
        tie       = req_a & req_b;
        win_b     = tie ? ~rr : req_b;
        win_we    = win_b ? we_b    : we_a;
        win_addr  = win_b ? addr_b  : addr_a;
        win_wdata = win_b ? wdata_b : wdata_a;
    end

    // Controller FSM; all handshake and regfile control outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 1'b1;
            lat_we   <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            clr_done <= 1'b0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            busy     <= 1'b0;
            rf_load  <= 1'b0;
            rf_clr   <= 1'b0;
            rf_addr  <= '0;
            rf_din   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        // A clear is served before any pending transaction.
                        state  <= CLR;
                        rf_clr <= 1'b1;
                        busy   <= 1'b1;
                    end else if (any_req) begin
                        state   <= XFER;
                        busy    <= 1'b1;
                        gnt_a   <= ~win_b;
                        gnt_b   <= win_b;
                        lat_we  <= win_we;
                        rf_addr <= win_addr;
                        rf_din  <= win_wdata;
                        rf_load <= win_we;
                        if (tie) begin
                            rr <= win_b;
                        end
                    end
                end
                XFER: begin
                    // Reads capture the regfile output; writes return the written data.
                    state   <= DONE;
                    rf_load <= 1'b0;
                    if (gnt_a) begin
                        ack_a   <= 1'b1;
                        rdata_a <= lat_we ? rf_din : rf_q;
                    end
                    if (gnt_b) begin
                        ack_b   <= 1'b1;
                        rdata_b <= lat_we ? rf_din : rf_q;
                    end
                end
                CLR: begin
                    state    <= DONE;
                    rf_clr   <= 1'b0;
                    clr_done <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    ack_a    <= 1'b0;
                    ack_b    <= 1'b0;
                    clr_done <= 1'b0;
                    gnt_a    <= 1'b0;
                    gnt_b    <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: bench for regfile_ctrl with a behavioural 8x4 regfile and a
// transaction-level reference model of its contents.
module tb_regfile_ctrl;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, we_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] wdata_a = '0;
    logic          ack_a;
    logic [DW-1:0] rdata_a;
    logic          req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          ack_b;
    logic [DW-1:0] rdata_b;
    logic          clr_req = 1'b0;
    logic          clr_done, gnt_a, gnt_b, busy, rf_load, rf_clr;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_q;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int n_load = 0;
    bit gnt_b_seen = 1'b0;

    logic [DW-1:0] mem   [8] = '{default: '0};
    logic [DW-1:0] model [8] = '{default: '0};
    logic [DW-1:0] exp_a, exp_b;

    int ord [8];
    int tk  [8];
    int n_ack;

    always #5 clk = ~clk;

    regfile_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .clr_done(clr_done),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .rf_load(rf_load), .rf_clr(rf_clr), .rf_addr(rf_addr), .rf_din(rf_din),
        .rf_q(rf_q)
    );

    // Behavioural register file driven by the controller.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (rf_load) begin
            mem[rf_addr] <= rf_din;
        end
    end
    assign rf_q = mem[rf_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level monitor: every completion is checked against the model.
    always @(negedge clk) begin
        if (rf_load) n_load++;
        if (gnt_b) gnt_b_seen = 1'b1;
        if (ack_a) begin
            chk("ack_a_has_req", req_a, 1);
            exp_a = we_a ? wdata_a : model[addr_a];
            if (we_a) model[addr_a] = wdata_a;
            chk("rdata_a", rdata_a, exp_a);
        end
        if (ack_b) begin
            chk("ack_b_has_req", req_b, 1);
            exp_b = we_b ? wdata_b : model[addr_b];
            if (we_b) model[addr_b] = wdata_b;
            chk("rdata_b", rdata_b, exp_b);
        end
        if (clr_done) begin
            for (int i = 0; i < 8; i++) model[i] = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic new_a(input bit rnd_we);
        we_a    = rnd_we ? 1'($urandom_range(0, 1)) : 1'b1;
        addr_a  = rnd_we ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
        wdata_a = 4'($urandom);
    endtask

    task automatic new_b(input bit rnd_we);
        we_b    = rnd_we ? 1'($urandom_range(0, 1)) : 1'b1;
        addr_b  = rnd_we ? 3'($urandom_range(0, 7)) : 3'($urandom_range(4, 7));
        wdata_b = 4'($urandom);
    endtask

    // One isolated transaction with cycle-exact latency checks.
    task automatic single(input bit who, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        if (who) begin we_b = we; addr_b = ad; wdata_b = d; req_b = 1'b1; end
        else     begin we_a = we; addr_a = ad; wdata_a = d; req_a = 1'b1; end
        tick();
        chk("xfer_gnt", who ? gnt_b : gnt_a, 1);
        chk("xfer_load", rf_load, we);
        chk("xfer_addr", rf_addr, ad);
        chk("xfer_busy", busy, 1);
        if (we) chk("xfer_din", rf_din, d);
        tick();
        chk("done_ack", who ? ack_b : ack_a, 1);
        chk("done_load", rf_load, 0);
        tick();
        if (who) req_b = 1'b0; else req_a = 1'b0;
        chk("idle_ack", who ? ack_b : ack_a, 0);
        chk("idle_gnt", gnt_a | gnt_b, 0);
        chk("idle_busy", busy, 0);
    endtask

    // Serve both requesters until n acks; refresh=1 re-issues a new write after each ack.
    task automatic run_pair(input int n, input bit refresh);
        bit da = 1'b0, db = 1'b0;
        n_ack = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (da) begin da = 1'b0; if (refresh && n_ack < n) new_a(1'b0); else req_a = 1'b0; end
            if (db) begin db = 1'b0; if (refresh && n_ack < n) new_b(1'b0); else req_b = 1'b0; end
            if (n_ack >= n) begin req_a = 1'b0; req_b = 1'b0; break; end
            if (ack_a) begin ord[n_ack] = 0; tk[n_ack] = cyc_n; n_ack++; da = 1'b1; end
            if (ack_b) begin ord[n_ack] = 1; tk[n_ack] = cyc_n; n_ack++; db = 1'b1; end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("pair_acks", n_ack, n);
    endtask

    initial begin
        int l0;
        int done_cnt;
        bit da, db, dc, stopping;

        // Reset state
        #1;
        chk("rst_ctrl", {ack_a, ack_b, clr_done, gnt_a, gnt_b, busy, rf_load}, 0);
        chk("rst_clr", rf_clr, 0);
        chk("rst_rdata", {rdata_a, rdata_b}, 0);
        chk("rst_rf_bus", {rf_addr, rf_din}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: A writes 0x5 to address 3
        l0 = n_load;
        single(1'b0, 1'b1, 3'd3, 4'h5);
        chk("t1_rdata_a", rdata_a, 4'h5);
        chk("t1_loads", n_load - l0, 1);
        chk("t1_gnt_b_seen", gnt_b_seen, 0);

        // Test 2: B reads address 3
        l0 = n_load;
        single(1'b1, 1'b0, 3'd3, 4'h0);
        chk("t2_loads", n_load - l0, 0);
        chk("t2_rdata_b", rdata_b, 4'h5);

        // Test 3: both held continuously, alternating grants
        do_reset();
        new_a(1'b0);
        new_b(1'b0);
        req_a = 1'b1;
        req_b = 1'b1;
        run_pair(6, 1'b1);
        for (int i = 0; i < 6; i++) chk("t3_order", ord[i], i % 2);
        for (int i = 1; i < 6; i++) chk("t3_spacing", tk[i] - tk[i-1], 3);
        for (int i = 0; i < 8; i++) chk("t3_scoreboard", mem[i], model[i]);

        // Test 4: clear and both requests rise together
        do_reset();
        new_a(1'b0);
        new_b(1'b0);
        req_a = 1'b1;
        req_b = 1'b1;
        clr_req = 1'b1;
        tick();
        chk("t4_rf_clr", rf_clr, 1);
        chk("t4_no_gnt", gnt_a | gnt_b, 0);
        chk("t4_clr_load", rf_load, 0);
        tick();
        chk("t4_clr_done", clr_done, 1);
        chk("t4_rf_clr_off", rf_clr, 0);
        for (int i = 0; i < 8; i++) chk("t4_cleared", mem[i], 0);
        clr_req = 1'b0;
        run_pair(2, 1'b0);
        chk("t4_first", ord[0], 0);
        chk("t4_second", ord[1], 1);

        // Test 5: reset during an A write
        do_reset();
        new_a(1'b0);
        req_a = 1'b1;
        tick();
        chk("t5_xfer_gnt", gnt_a, 1);
        chk("t5_xfer_load", rf_load, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", {ack_a, gnt_a, rf_load, busy}, 0);
        req_a = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        new_a(1'b0);
        new_b(1'b0);
        req_a = 1'b1;
        req_b = 1'b1;
        run_pair(2, 1'b0);
        chk("t5_tie_a_first", ord[0], 0);

        // Test 6: random traffic from both requesters plus occasional clears
        done_cnt = 0;
        da = 1'b0; db = 1'b0; dc = 1'b0; stopping = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            stopping = (done_cnt >= 32);
            if (da) begin
                da = 1'b0;
                if (!stopping && $urandom_range(0, 1) == 1) new_a(1'b1); else req_a = 1'b0;
            end else if (!stopping && !req_a && $urandom_range(0, 2) == 0) begin
                new_a(1'b1);
                req_a = 1'b1;
            end
            if (db) begin
                db = 1'b0;
                if (!stopping && $urandom_range(0, 1) == 1) new_b(1'b1); else req_b = 1'b0;
            end else if (!stopping && !req_b && $urandom_range(0, 2) == 0) begin
                new_b(1'b1);
                req_b = 1'b1;
            end
            if (dc) begin
                dc = 1'b0;
                clr_req = 1'b0;
            end else if (!stopping && !clr_req && $urandom_range(0, 19) == 0) begin
                clr_req = 1'b1;
            end
            if (ack_a) begin da = 1'b1; done_cnt++; end
            if (ack_b) begin db = 1'b1; done_cnt++; end
            if (clr_done) dc = 1'b1;
            if (stopping && !req_a && !req_b && !clr_req && !busy && !da && !db && !dc) break;
        end
        chk("t6_completed", done_cnt >= 32, 1);
        chk("t6_drained", busy, 0);
        req_a = 1'b0;
        req_b = 1'b0;
        clr_req = 1'b0;
        for (int i = 0; i < 8; i++) chk("t6_scoreboard", mem[i], model[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Two-requester controller and arbiter for the shared 8x4 register file (ports load, clr, addr, din, q).
- Two clients (A, B) each issue single read or write transactions with a req/ack handshake.
- Grants use round-robin arbitration.
- A separate clear request sequences a one-cycle register-file clear.
- Sits directly in front of the regfile instance and owns all of its control inputs.

Parameters:
- AW, 3, register-file address width (2**AW entries)
- DW, 4, register-file data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A transaction request (level)
- we_a  in  1  A: 1=write, 0=read
- addr_a  in  AW  A: target address
- wdata_a  in  DW  A: write data
- ack_a  out  1  A: one-cycle completion pulse
- rdata_a  out  DW  A: read result, valid when ack_a=1
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as A for requester B
- clr_req  in  1  clear-all request (level, held until clr_done)
- clr_done  out  1  one-cycle pulse when clear completes
- gnt_a  out  1  A owns the current transaction (XFER/DONE)
- gnt_b  out  1  B owns the current transaction
- busy  out  1  state != IDLE
- rf_load  out  1  to regfile load
- rf_clr  out  1  to regfile clr
- rf_addr  out  AW  to regfile addr
- rf_din  out  DW  to regfile din
- rf_q  in  DW  regfile combinational read data for rf_addr

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; rr pointer=B, so A wins the first tie.
  - All outputs 0, including rdata_a/b, rf_addr and rf_din.
  - Regfile contents are not touched: rf_clr stays 0 during reset.
- States: IDLE, XFER, CLR, DONE. All outputs are registered.
- IDLE:
  - If clr_req=1: go to CLR. Clear beats pending requests.
  - Else if exactly one of req_a/req_b is set: grant that requester.
  - Else if both are set: grant the requester not pointed to by rr, then set rr to the winner.
  - On a grant: latch we/addr/wdata of the winner, set gnt_x, go to XFER.
  - Else stay in IDLE.
- XFER (1 cycle):
  - rf_addr=latched addr.
  - rf_din=latched wdata.
  - rf_load=latched we.
  - At the closing edge: rdata_x <= rf_q for reads, or latched wdata for writes (write-through). Then go to DONE.
- CLR (1 cycle): rf_clr=1, rf_load=0; go to DONE with clear flag set.
- DONE (1 cycle):
  - Pulse ack_x or clr_done.
  - rf_load=0, rf_clr=0.
  - gnt_x holds through DONE and drops on return to IDLE.
- Latency: request sampled at edge N; XFER is cycle N+1; ack is cycle N+2; the next grant is no earlier than N+3.
- Requester rules:
  - Hold req and the command stable until ack.
  - Drop req after the ack cycle. A req still high in IDLE after ack is a new transaction.
- rdata_x holds its value until the next ack for that requester. It is not cleared by a regfile clear.
- Command fields of a non-granted requester are ignored; changes by the loser during XFER have no effect.
- clr_req asserted during XFER/DONE:
  - The transaction completes.
  - CLR wins in the next IDLE even if reqs are pending.
  - rr is unchanged by a clear.
- rst_n asserted mid-XFER: the write may or may not have occurred. No ack or clr_done is issued. Outputs go to 0 immediately.
- rf_addr and rf_din hold their last values outside XFER. rf_load is high only in XFER with we=1.

Test Plan:
1. Reset, A writes 0x5 @addr 3 alone -> rf_load=1 for exactly one cycle with rf_addr=3, rf_din=0x5; ack_a at +2 cycles; rdata_a=0x5; gnt_b never set.
2. B reads addr 3 after test 1 -> rf_load stays 0; ack_b at +2 cycles; rdata_b=0x5.
3. req_a and req_b both held continuously with distinct writes -> grants alternate A,B,A,B (A first after reset); each ack spaced 3 cycles; regfile scoreboard matches.
4. Both reqs and clr_req rise in the same IDLE cycle -> CLR first (rf_clr one cycle, clr_done pulse); then A served, then B; all 8 addresses read back 0 before the post-clear writes.
5. rst_n pulsed low during XFER of an A write -> ack_a, gnt_a, rf_load and busy drop immediately; after release A wins the next tie again (rr=B).
6. 32 random read/write transactions from both requesters against a reference model -> every rdata matches the model; no ack without a prior req; zero errors.
